imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational sign_extension unit in the RV32I decode path.
- Derives the opcode from inst[6:0]. Produces the XLEN-wide extended immediate, its format code and an illegal flag.
- Registered valid/ready output with a 2-entry skid buffer. Sits between fetch/IF-ID and the operand mux.
- Carries a user tag (e.g. PC or ROB id) alongside each result.

---
 rtl/imm_gen_pipe_pkg.sv | 35 +++
 rtl/imm_gen_pipe_imm_decode.sv | 76 +++++++
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared RV32I decode constants, immediate format codes and skid-buffer states
// for the pipelined immediate generator.
package imm_gen_pipe_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned OPCODE     = 7;

  localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_CSR = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational RV32I immediate decoder, sign-extended from bit 31 to XLEN.
// IMM_ZICSR_EN: decode csrr*i zimm as a zero-extended CSR immediate.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [XLEN-1:0]       imm_o,
  output imm_fmt_e              fmt_o,
  output logic                  illegal_o
);

  logic [OPCODE-1:0] opcode;
  logic [31:0]       imm32;

  always_comb begin
    opcode    = inst_i[OPCODE-1:0];
    imm32     = '0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      unique case (opcode)
        OP_ALUI, OP_LOAD, OP_JALR: begin
          imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
          fmt_o = FMT_I;
        end
        OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
          if (inst_i[14]) begin
            imm32 = {27'b0, inst_i[19:15]};
            fmt_o = FMT_CSR;
          end else begin
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            fmt_o = FMT_I;
          end
`else
          imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
          fmt_o = FMT_I;
`endif
        end
        OP_STORE: begin
          imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
          fmt_o = FMT_S;
        end
        OP_BRANCH: begin
          imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
          fmt_o = FMT_B;
        end
        OP_LUI, OP_AUIPC: begin
          imm32 = {inst_i[31:12], 12'b0};
          fmt_o = FMT_U;
        end
        OP_JAL: begin
          imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};
          fmt_o = FMT_J;
        end
        OP_ALU: begin
          imm32 = '0;
          fmt_o = FMT_R;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
    // CSR zimm has bit 31 clear, so a single sign-extension covers every format.
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate generator with a 2-entry skid buffer and tag
// pass-through. Decode behaviour depends on IMM_ZICSR_EN (see imm_decode).
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       imm_o,
  output imm_fmt_e              fmt_o,
  output logic                  illegal_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (inst_i),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  buf_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] imm_q, imm_d, skid_imm_q, skid_imm_d;
  imm_fmt_e        fmt_q, fmt_d, skid_fmt_q, skid_fmt_d;
  logic            ill_q, ill_d, skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] tag_q, tag_d, skid_tag_q, skid_tag_d;

  logic accept;
  logic drain;

  always_comb begin
    accept     = in_valid_i & in_ready_q;
    drain      = out_valid_q & out_ready_i;
    state_d    = state_q;
    imm_d      = imm_q;
    fmt_d      = fmt_q;
    ill_d      = ill_q;
    tag_d      = tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          imm_d   = dec_imm;
          fmt_d   = dec_fmt;
          ill_d   = dec_ill;
          tag_d   = tag_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && drain) begin
          imm_d = dec_imm;
          fmt_d = dec_fmt;
          ill_d = dec_ill;
          tag_d = tag_i;
        end else if (accept) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_ill_d = dec_ill;
          skid_tag_d = tag_i;
          state_d    = BUF_TWO;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          imm_d   = skid_imm_q;
          fmt_d   = skid_fmt_q;
          ill_d   = skid_ill_q;
          tag_d   = skid_tag_q;
          state_d = BUF_ONE;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    out_valid_d = (state_d != BUF_EMPTY);
    in_ready_d  = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BUF_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      imm_q       <= '0;
      fmt_q       <= FMT_R;
      ill_q       <= 1'b0;
      tag_q       <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_R;
      skid_ill_q  <= 1'b0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      imm_q       <= imm_d;
      fmt_q       <= fmt_d;
      ill_q       <= ill_d;
      tag_q       <= tag_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign imm_o       = imm_q;
  assign fmt_o       = fmt_q;
  assign illegal_o   = ill_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic [31:0] tag = '0;

  logic        in_ready32, in_ready64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  imm_fmt_e    fmt32, fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .inst_i(inst), .tag_i(tag), .out_valid_o(ov32), .out_ready_i(out_ready),
    .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32), .tag_o(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .inst_i(inst), .tag_i(tag), .out_valid_o(ov64), .out_ready_i(out_ready),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64), .tag_o(tag64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  // Reference decode: immediate value computed as a signed integer.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] t);
    exp_t   e;
    longint v;
    v     = 0;
    e.fmt = FMT_R;
    e.ill = 1'b0;
    e.tag = t;
    if (i[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (i[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          v = longint'($signed(i[31:20])); e.fmt = FMT_I;
        end
        7'b1110011: begin
`ifdef IMM_ZICSR_EN
          if (i[14]) begin
            v = longint'(i[19:15]); e.fmt = FMT_CSR;
          end else begin
            v = longint'($signed(i[31:20])); e.fmt = FMT_I;
          end
`else
          v = longint'($signed(i[31:20])); e.fmt = FMT_I;
`endif
        end
        7'b0100011: begin
          v = longint'($signed({i[31:25], i[11:7]})); e.fmt = FMT_S;
        end
        7'b1100011: begin
          v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); e.fmt = FMT_B;
        end
        7'b0110111, 7'b0010111: begin
          v = longint'($signed(i[31:12])) * 4096; e.fmt = FMT_U;
        end
        7'b1101111: begin
          v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); e.fmt = FMT_J;
        end
        7'b0110011: begin
          v = 0; e.fmt = FMT_R;
        end
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = 64'(v);
    return e;
  endfunction

  exp_t q[$];
  bit   fresh = 1'b1;
  bit   started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      fresh   = 1'b1;
      started = 1'b1;
    end else begin
      bit acc, drn;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(model(inst, tag));
        fresh = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid32", ov32, q.size() > 0);
      chk("out_valid64", ov64, q.size() > 0);
      chk("in_ready32", in_ready32, q.size() < 2);
      chk("in_ready64", in_ready64, q.size() < 2);
      if (q.size() > 0) begin
        chk("imm32", imm32, q[0].imm[31:0]);
        chk("imm64", imm64, q[0].imm);
        chk("fmt32", fmt32, q[0].fmt);
        chk("fmt64", fmt64, q[0].fmt);
        chk("ill32", ill32, q[0].ill);
        chk("ill64", ill64, q[0].ill);
        chk("tag32", tag32, q[0].tag);
        chk("tag64", tag64, q[0].tag);
      end else if (fresh) begin
        chk("rst_imm32", imm32, 0);
        chk("rst_imm64", imm64, 0);
        chk("rst_fmt32", fmt32, FMT_R);
        chk("rst_ill32", ill32, 0);
        chk("rst_tag32", tag32, 0);
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] t);
    bit done;
    done     = 1'b0;
    inst     = i;
    tag      = t;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready32) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected accept of %h", i);
    end
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("lit_rst_valid", ov32, 0);
    chk("lit_rst_ready", in_ready32, 1);
    chk("lit_rst_imm", imm32, 0);
    chk("lit_rst_fmt", fmt32, FMT_R);
    chk("lit_rst_tag", tag32, 0);

    out_ready = 1'b1;
    send(32'h8000_0013, 32'd10);
    chk("lit_alui_imm32", imm32, 32'hffff_f800);
    chk("lit_alui_fmt", fmt32, FMT_I);
    chk("lit_alui_imm64", imm64, 64'hffff_ffff_ffff_f800);
    send(32'hfe41_04e3, 32'd11);
    chk("lit_branch_imm32", imm32, 32'hffff_ffe8);
    chk("lit_branch_fmt", fmt32, FMT_B);
    send(32'hf19f_f26f, 32'd12);
    chk("lit_jal_imm32", imm32, 32'hffff_ff18);
    chk("lit_jal_fmt", fmt32, FMT_J);
    send(32'h8000_00b7, 32'd13);
    chk("lit_lui_imm32", imm32, 32'h8000_0000);
    chk("lit_lui_imm64", imm64, 64'hffff_ffff_8000_0000);
    chk("lit_lui_fmt", fmt64, FMT_U);
    send(32'h0000_0000, 32'd14);
    chk("lit_zero_ill", ill32, 1);
    chk("lit_zero_imm", imm32, 0);
    chk("lit_zero_fmt", fmt32, FMT_R);
    send(32'h0000_000b, 32'd15);
    chk("lit_custom_ill", ill32, 1);
    send(32'h3401_d073, 32'd16);
`ifdef IMM_ZICSR_EN
    chk("lit_csr_imm", imm32, 32'h0000_0003);
    chk("lit_csr_fmt", fmt32, FMT_CSR);
`else
    chk("lit_csr_imm", imm32, 32'h0000_0340);
    chk("lit_csr_fmt", fmt32, FMT_I);
`endif
    step();

    // Backpressure: two beats fill the buffer, the third waits at the input.
    out_ready = 1'b0;
    send(32'h0001_70b7, 32'd1);
    send(32'h00c0_0167, 32'd2);
    inst     = 32'h80f8_0023;
    tag      = 32'd3;
    in_valid = 1'b1;
    step();
    chk("lit_bp_ready", in_ready32, 0);
    chk("lit_bp_hold_imm", imm32, 32'h0001_7000);
    chk("lit_bp_hold_tag", tag32, 1);
    out_ready = 1'b1;
    chk("lit_bp_r1_imm", imm32, 32'h0001_7000);
    step();
    chk("lit_bp_r2_imm", imm32, 32'h0000_000c);
    chk("lit_bp_r2_tag", tag32, 2);
    step();
    in_valid = 1'b0;
    chk("lit_bp_r3_valid", ov32, 1);
    chk("lit_bp_r3_imm", imm32, 32'hffff_f800);
    chk("lit_bp_r3_tag", tag32, 3);
    step();

    // Reset with two beats buffered and a third offered in the reset cycle.
    out_ready = 1'b0;
    send(32'h0010_0013, 32'd20);
    send(32'h0020_0013, 32'd21);
    inst     = 32'h0030_0013;
    tag      = 32'd22;
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("lit_mrst_valid", ov32, 0);
    chk("lit_mrst_ready", in_ready32, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lit_mrst_no_stale", ov32, 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
